// File: rtl/prog_run_ctrl.sv
// Run controller that gates the PC count enable. It handles launch, halt, stall, cycle counting and an optional watchdog.
// The optional single-step gating is enabled by defining PROG_RUN_STEP_EN.
module prog_run_ctrl #(
  parameter int CYCLE_W    = 16,
  parameter int MAX_CYCLES = 0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Halt,
  input  logic               Stall,
`ifdef PROG_RUN_STEP_EN
  input  logic               StepMode,
  input  logic               Step,
`endif
  output logic               CountEn,
  output logic               Busy,
  output logic               Done,
  output logic               TimedOut,
  output logic [CYCLE_W-1:0] CycleCnt,
  output logic [2:0]         State
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    RUN     = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

  localparam bit               WD_EN   = (MAX_CYCLES != 0);
  localparam logic [CYCLE_W-1:0] WD_LAST = CYCLE_W'(MAX_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] CNT_SAT = '1;

  state_t             state, state_nxt;
  logic [CYCLE_W-1:0] cnt, cnt_nxt;
  logic               step_ok;

`ifdef PROG_RUN_STEP_EN
  logic step_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) step_q <= 1'b0;
    else       step_q <= Step;
  end

  // A pulse lost to a stall is not retried: step_q has already advanced.
  assign step_ok = ~StepMode | (Step & ~step_q);
`else
  assign step_ok = 1'b1;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    CountEn   = (state == RUN) & ~Stall & ~Halt & ~Start & step_ok;
    case (state)
      IDLE:  if (Start) state_nxt = ARMED;
      ARMED: begin
        if (!Start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        if (CountEn && cnt != CNT_SAT) cnt_nxt = cnt + CYCLE_W'(1);
        if (Start)                                     state_nxt = ARMED;
        else if (Halt)                                 state_nxt = DONE;
        else if (WD_EN && CountEn && cnt == WD_LAST)   state_nxt = TIMEOUT;
      end
      DONE, TIMEOUT: if (Start) state_nxt = ARMED;
      default: state_nxt = IDLE;
    endcase
  end

  assign Busy     = (state == ARMED) | (state == RUN);
  assign Done     = (state == DONE) | (state == TIMEOUT);
  assign TimedOut = (state == TIMEOUT);
  assign CycleCnt = cnt;
  assign State    = state;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Directed bench for prog_run_ctrl: default instance, a MAX_CYCLES=20 watchdog instance and a 4-bit saturation instance share one stimulus.
module tb_prog_run_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, halt = 1'b0, stall = 1'b0;
  logic step_mode = 1'b0, step = 1'b0;
  logic        cen, busy, done, tmo;
  logic [15:0] cnt;
  logic [2:0]  st;
  logic        wd_cen, wd_busy, wd_done, wd_tmo;
  logic [15:0] wd_cnt;
  logic [2:0]  wd_st;
  logic        sat_cen, sat_busy, sat_done, sat_tmo;
  logic [3:0]  sat_cnt;
  logic [2:0]  sat_st;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  prog_run_ctrl dut (
    .Clk(clk), .Reset(rst), .Start(start), .Halt(halt), .Stall(stall),
`ifdef PROG_RUN_STEP_EN
    .StepMode(step_mode), .Step(step),
`endif
    .CountEn(cen), .Busy(busy), .Done(done), .TimedOut(tmo), .CycleCnt(cnt), .State(st)
  );

  prog_run_ctrl #(.CYCLE_W(16), .MAX_CYCLES(20)) dut_wd (
    .Clk(clk), .Reset(rst), .Start(start), .Halt(halt), .Stall(stall),
`ifdef PROG_RUN_STEP_EN
    .StepMode(step_mode), .Step(step),
`endif
    .CountEn(wd_cen), .Busy(wd_busy), .Done(wd_done), .TimedOut(wd_tmo), .CycleCnt(wd_cnt), .State(wd_st)
  );

  prog_run_ctrl #(.CYCLE_W(4), .MAX_CYCLES(0)) dut_sat (
    .Clk(clk), .Reset(rst), .Start(start), .Halt(halt), .Stall(stall),
`ifdef PROG_RUN_STEP_EN
    .StepMode(step_mode), .Step(step),
`endif
    .CountEn(sat_cen), .Busy(sat_busy), .Done(sat_done), .TimedOut(sat_tmo), .CycleCnt(sat_cnt), .State(sat_st)
  );

  // Every action happens 2 time units after a rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic launch();
    start = 1'b1; tick();
    start = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; #1;
    total++; if (st !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", st); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    total++; if ({cen, busy, done, tmo} !== 4'b0000) begin bad++; $display("FAIL reset_outs got=%b exp=0000", {cen, busy, done, tmo}); end
    tick(); rst = 1'b0; tick();
    total++; if ({cen, busy, done, tmo, st} !== 7'b0) begin bad++; $display("FAIL post_reset got=%b exp=0", {cen, busy, done, tmo, st}); end
  endtask

  task automatic test_launch();
    start = 1'b1; tick();
    total++; if (st !== 3'd1 || busy !== 1'b1) begin bad++; $display("FAIL armed got st=%0d busy=%b exp st=1 busy=1", st, busy); end
    tick(); tick();
    start = 1'b0; #1;
    total++; if (cen !== 1'b0 || st !== 3'd1) begin bad++; $display("FAIL armed_wait got cen=%b st=%0d exp 0/1", cen, st); end
    tick();
    total++; if (st !== 3'd2 || busy !== 1'b1) begin bad++; $display("FAIL run_entry got st=%0d busy=%b exp st=2 busy=1", st, busy); end
    for (int i = 0; i < 10; i++) begin
      #1;
      total++; if (cen !== 1'b1 || cnt !== 16'(i)) begin bad++; $display("FAIL run_count got cen=%b cnt=%0d exp cen=1 cnt=%0d", cen, cnt, i); end
      tick();
    end
  endtask

  task automatic test_halt();
    halt = 1'b1; #1;
    total++; if (cen !== 1'b0) begin bad++; $display("FAIL halt_cen got=%b exp=0", cen); end
    tick(); halt = 1'b0; #1;
    total++; if (st !== 3'd3 || done !== 1'b1 || busy !== 1'b0 || tmo !== 1'b0) begin bad++; $display("FAIL halt_done got st=%0d done=%b busy=%b tmo=%b exp 3/1/0/0", st, done, busy, tmo); end
    tick(); tick();
    total++; if (cnt !== 16'd10 || st !== 3'd3 || cen !== 1'b0) begin bad++; $display("FAIL halt_hold got cnt=%0d st=%0d cen=%b exp 10/3/0", cnt, st, cen); end
  endtask

  task automatic test_restart();
    start = 1'b1; tick();
    total++; if (st !== 3'd1 || cnt !== 16'd10) begin bad++; $display("FAIL restart_armed got st=%0d cnt=%0d exp 1/10", st, cnt); end
    start = 1'b0; tick();
    total++; if (st !== 3'd2 || cnt !== 16'd0) begin bad++; $display("FAIL restart_run got st=%0d cnt=%0d exp 2/0", st, cnt); end
    tick(); tick();
    total++; if (cnt !== 16'd2) begin bad++; $display("FAIL restart_count got=%0d exp=2", cnt); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (cen !== 1'b0) begin bad++; $display("FAIL stall_cen cycle %0d got=%b exp=0", i, cen); end
      tick();
      total++; if (cnt !== 16'd2 || st !== 3'd2) begin bad++; $display("FAIL stall_hold cycle %0d got cnt=%0d st=%0d exp 2/2", i, cnt, st); end
    end
    stall = 1'b0; #1;
    total++; if (cen !== 1'b1) begin bad++; $display("FAIL stall_resume got=%b exp=1", cen); end
    tick();
    total++; if (cnt !== 16'd3) begin bad++; $display("FAIL stall_resume_cnt got=%0d exp=3", cnt); end
  endtask

  task automatic test_halt_stall();
    halt = 1'b1; stall = 1'b1; tick();
    halt = 1'b0; stall = 1'b0; #1;
    total++; if (st !== 3'd3 || cnt !== 16'd3) begin bad++; $display("FAIL halt_stall got st=%0d cnt=%0d exp 3/3", st, cnt); end
  endtask

  task automatic test_abort();
    launch(); tick();
    start = 1'b1; #1;
    total++; if (cen !== 1'b0) begin bad++; $display("FAIL abort_cen got=%b exp=0", cen); end
    tick();
    total++; if (st !== 3'd1 || cnt !== 16'd1) begin bad++; $display("FAIL abort_armed got st=%0d cnt=%0d exp 1/1", st, cnt); end
    start = 1'b0; tick(); tick(); tick();
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1; #1;
    total++; if (st !== 3'd0 || cnt !== 16'd0 || cen !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_reset got st=%0d cnt=%0d cen=%b busy=%b exp 0/0/0/0", st, cnt, cen, busy); end
    tick(); rst = 1'b0; tick();
    total++; if (st !== 3'd0 || cen !== 1'b0) begin bad++; $display("FAIL mid_reset_release got st=%0d cen=%b exp 0/0", st, cen); end
  endtask

  task automatic test_watchdog();
    launch();
    for (int i = 0; i < 19; i++) tick();
    total++; if (wd_st !== 3'd2 || wd_cnt !== 16'd19 || wd_cen !== 1'b1) begin bad++; $display("FAIL wd_pre got st=%0d cnt=%0d cen=%b exp 2/19/1", wd_st, wd_cnt, wd_cen); end
    tick();
    total++; if (wd_st !== 3'd4 || wd_tmo !== 1'b1 || wd_done !== 1'b1 || wd_cnt !== 16'd20) begin bad++; $display("FAIL wd_timeout got st=%0d tmo=%b done=%b cnt=%0d exp 4/1/1/20", wd_st, wd_tmo, wd_done, wd_cnt); end
    total++; if (st !== 3'd2 || cnt !== 16'd20 || tmo !== 1'b0) begin bad++; $display("FAIL wd_disabled got st=%0d cnt=%0d tmo=%b exp 2/20/0", st, cnt, tmo); end
    tick();
    total++; if (wd_cnt !== 16'd20 || wd_cen !== 1'b0 || wd_busy !== 1'b0) begin bad++; $display("FAIL wd_hold got cnt=%0d cen=%b busy=%b exp 20/0/0", wd_cnt, wd_cen, wd_busy); end
    total++; if (sat_cnt !== 4'hF || sat_st !== 3'd2 || sat_cen !== 1'b1) begin bad++; $display("FAIL saturate got cnt=%0d st=%0d cen=%b exp 15/2/1", sat_cnt, sat_st, sat_cen); end
    start = 1'b1; tick(); start = 1'b0;
    total++; if (wd_st !== 3'd1) begin bad++; $display("FAIL wd_rearm got st=%0d exp=1", wd_st); end
    tick();
  endtask

`ifdef PROG_RUN_STEP_EN
  task automatic test_step();
    logic [13:0] pattern;
    int pulses;
    pattern = 14'b00010011111001;
    pulses = 0;
    step_mode = 1'b1; step = 1'b0;
    launch();
    for (int i = 0; i < 14; i++) begin
      step = pattern[i]; #1;
      if (cen === 1'b1) pulses++;
      tick();
    end
    total++; if (pulses != 3) begin bad++; $display("FAIL step_pulses got=%0d exp=3", pulses); end
    total++; if (cnt !== 16'd3 || st !== 3'd2) begin bad++; $display("FAIL step_cnt got cnt=%0d st=%0d exp 3/2", cnt, st); end
    step_mode = 1'b0; step = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_launch();
    test_halt();
    test_restart();
    test_stall();
    test_halt_stall();
    test_abort();
    test_reset_mid_run();
    test_watchdog();
`ifdef PROG_RUN_STEP_EN
    test_step();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
